encrypt_pipe_elastic: RTL

Parametrised successor to the fixed 12-round, 32-bit encrypt pipeline. It runs ROUNDS iterations of the xor/conditional-add/rotate round over DW-bit words, with valid/ready backpressure on both sides. Each transaction can carry its own key and a sideband tag. A flush input empties the pipeline. Data registers load only on an accepted advance, so synthesis can infer clock gating. It sits between a producer stream and a stalling consumer (DMA/FIFO).

---
 rtl/encrypt_pipe_elastic_pkg.sv | 31 +++
 rtl/encrypt_pipe_elastic_if.sv | 29 ++
 rtl/encrypt_pipe_elastic_round_stage.sv | 72 +++++++
 rtl/encrypt_pipe_elastic.sv | 97 +++++++++
 4 files changed

// File: rtl/encrypt_pipe_elastic_pkg.sv
// Shared constants and round arithmetic for the elastic encrypt pipeline.
// Width-generic helpers operate on a MAX_DW container and mask down to dw.
package encrypt_pkg;

  localparam int          MAX_DW        = 128;
  localparam logic [31:0] CONST_DEFAULT = 32'h4cfedf05;

  typedef logic [MAX_DW-1:0] word_t;

  function automatic int round_rot(input int r, input int dw);
    return (r + 1) % dw;
  endfunction

  function automatic int key_idx(input int r, input int nk);
    return r % nk;
  endfunction

  // xor with key word, add the constant when x is odd, rotate right
  function automatic word_t enc_round(input word_t x, input word_t kw, input word_t cst,
                                      input int r, input int dw);
    word_t mask;
    word_t a;
    int    rot;
    mask = (dw >= MAX_DW) ? '1 : ((word_t'(1) << dw) - word_t'(1));
    a    = ((x ^ kw) + (x[0] ? cst : '0)) & mask;
    rot  = round_rot(r, dw);
    if (rot == 0) return a;
    return ((a >> rot) | (a << (dw - rot))) & mask;
  endfunction

endpackage

// File: rtl/encrypt_pipe_elastic_if.sv
// Producer/consumer stream bundle for encrypt_pipe_elastic.
// master = the traffic side (producer + consumer), slave = the pipeline.
interface encrypt_pipe_elastic_if #(
  parameter int DW = 32,
  parameter int NK = 4,
  parameter int TW = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    in_data;
  logic [NK*DW-1:0] in_key;
  logic [TW-1:0]    in_tag;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out_data;
  logic [TW-1:0]    out_tag;
  logic             busy;

  modport master (
    output in_valid, in_data, in_key, in_tag, flush, out_ready,
    input  in_ready, out_valid, out_data, out_tag, busy
  );

  modport slave (
    input  in_valid, in_data, in_key, in_tag, flush, out_ready,
    output in_ready, out_valid, out_data, out_tag, busy
  );
endinterface

// File: rtl/encrypt_pipe_elastic_round_stage.sv
// One elastic round stage: valid/ready slot whose payload registers load
// only on an accepted advance from upstream.
module encrypt_round_stage
  import encrypt_pkg::*;
#(
  parameter int             DW       = 32,
  parameter int             NK       = 4,
  parameter int             TW       = 4,
  parameter int             KEY_PIPE = 1,
  parameter int             R        = 1,
  parameter logic [DW-1:0]  CST      = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             up_valid_i,
  input  logic [DW-1:0]    up_data_i,
  input  logic [NK*DW-1:0] up_key_i,
  input  logic [TW-1:0]    up_tag_i,
  input  logic [NK*DW-1:0] live_key_i,
  input  logic             dn_ready_i,
  output logic             rdy_o,
  output logic             valid_o,
  output logic [DW-1:0]    data_o,
  output logic [NK*DW-1:0] key_o,
  output logic [TW-1:0]    tag_o
);
  localparam int KI = key_idx(R, NK);

  logic          v_q, v_d, load;
  logic [DW-1:0] data_q, data_d, kw;
  logic [TW-1:0] tag_q;
  logic          unused_keys;

  assign rdy_o  = !v_q || dn_ready_i;
  assign load   = up_valid_i && rdy_o;
  assign kw     = (KEY_PIPE != 0) ? up_key_i[KI*DW +: DW] : live_key_i[KI*DW +: DW];
  assign data_d = DW'(enc_round(word_t'(up_data_i), word_t'(kw), word_t'(CST), R, DW));
  // only one key word per stage is consumed; the rest just pass through
  assign unused_keys = ^{up_key_i, live_key_i};

  always_comb begin
    v_d = v_q;
    if (flush_i)    v_d = 1'b0;
    else if (rdy_o) v_d = up_valid_i;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) v_q <= 1'b0;
    else     v_q <= v_d;

  always_ff @(posedge clk)
    if (load) begin
      data_q <= data_d;
      tag_q  <= up_tag_i;
    end

  generate
    if (KEY_PIPE != 0) begin : g_key
      logic [NK*DW-1:0] key_q;
      always_ff @(posedge clk)
        if (load) key_q <= up_key_i;
      assign key_o = key_q;
    end else begin : g_key_live
      assign key_o = live_key_i;
    end
  endgenerate

  assign valid_o = v_q;
  assign data_o  = data_q;
  assign tag_o   = tag_q;
endmodule

// File: rtl/encrypt_pipe_elastic.sv
// Elastic ROUNDS-stage encrypt pipeline: whitening stage 0 plus a chain of
// round stages, collapsing bubbles under backpressure, with flush and busy.
module encrypt_pipe_elastic
  import encrypt_pkg::*;
#(
  parameter int          DW       = 32,
  parameter int          ROUNDS   = 12,
  parameter int          NK       = 4,
  parameter int          TW       = 4,
  parameter int          KEY_PIPE = 1,
  parameter logic [31:0] CONST    = CONST_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  encrypt_pipe_elastic_if.slave  bus
);
  localparam logic [DW-1:0] CST = DW'(CONST);

  logic [ROUNDS:0]              vld_pipe;
  logic [ROUNDS+1:0]            rdy;
  logic [ROUNDS:0][DW-1:0]      s;
  logic [ROUNDS:0][NK*DW-1:0]   k;
  logic [ROUNDS:0][TW-1:0]      t;

  logic             v0_q, v0_d, acc;
  logic [DW-1:0]    s0_q, s0_d;
  logic [TW-1:0]    t0_q;
  logic             unused_last_key;

  assign rdy[ROUNDS+1] = bus.out_ready;
  assign rdy[0]        = !v0_q || rdy[1];
  assign bus.in_ready  = rdy[0] && !bus.flush;
  assign acc           = bus.in_valid && bus.in_ready;
  assign s0_d          = bus.in_data ^ CST;

  always_comb begin
    v0_d = v0_q;
    if (bus.flush)   v0_d = 1'b0;
    else if (rdy[0]) v0_d = bus.in_valid;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) v0_q <= 1'b0;
    else     v0_q <= v0_d;

  always_ff @(posedge clk)
    if (acc) begin
      s0_q <= s0_d;
      t0_q <= bus.in_tag;
    end

  generate
    if (KEY_PIPE != 0) begin : g_key0
      logic [NK*DW-1:0] k0_q;
      always_ff @(posedge clk)
        if (acc) k0_q <= bus.in_key;
      assign k[0] = k0_q;
    end else begin : g_key0_live
      assign k[0] = bus.in_key;
    end
  endgenerate

  assign vld_pipe[0] = v0_q;
  assign s[0]        = s0_q;
  assign t[0]        = t0_q;

  generate
    for (genvar r = 1; r <= ROUNDS; r++) begin : g_stage
      encrypt_round_stage #(
        .DW(DW), .NK(NK), .TW(TW), .KEY_PIPE(KEY_PIPE), .R(r), .CST(CST)
      ) u_stage (
        .clk       (clk),
        .rst       (rst),
        .flush_i   (bus.flush),
        .up_valid_i(vld_pipe[r-1]),
        .up_data_i (s[r-1]),
        .up_key_i  (k[r-1]),
        .up_tag_i  (t[r-1]),
        .live_key_i(bus.in_key),
        .dn_ready_i(rdy[r+1]),
        .rdy_o     (rdy[r]),
        .valid_o   (vld_pipe[r]),
        .data_o    (s[r]),
        .key_o     (k[r]),
        .tag_o     (t[r])
      );
    end
  endgenerate

  // the last stage's key has no downstream consumer
  assign unused_last_key = ^k[ROUNDS];

  assign bus.out_valid = vld_pipe[ROUNDS];
  assign bus.out_data  = s[ROUNDS];
  assign bus.out_tag   = t[ROUNDS];
  assign bus.busy      = |vld_pipe;
endmodule
